// File: rtl/btn_bounce_gen.sv
// Contact-bounce generator: turns each clean_in transition into an LFSR-spaced
// toggle burst for a fixed window, then settles bouncy_out to the new level.
module btn_bounce_gen #(
    parameter int          BOUNCE_CYCLES = 50000,
    parameter int          MIN_SEG       = 8,
    parameter int          SEG_BITS      = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clean_in,
    output logic        bouncy_out,
    output logic        bouncing,
    output logic        settle_pulse,
    output logic [15:0] glitch_cnt
);
    localparam int WIN_W   = $clog2(BOUNCE_CYCLES + 1);
    localparam int SEG_MAX = MIN_SEG - 1 + (1 << SEG_BITS) - 1;
    localparam int SEG_W   = $clog2(SEG_MAX + 1);

    typedef enum logic {IDLE, BOUNCE} state_t;

    state_t             state, state_nxt;
    logic               clean_q;
    logic               target, target_nxt;
    logic [15:0]        lfsr, lfsr_nxt;
    logic [WIN_W-1:0]   win_cnt, win_nxt;
    logic [SEG_W-1:0]   seg_cnt, seg_nxt, seg_load;
    logic [15:0]        glitch_nxt;
    logic               bouncy_nxt, bouncing_nxt, settle_nxt;
    logic               change;
    logic [15:0]        lfsr_adv;

    assign change   = (clean_in != clean_q);
    assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign seg_load = SEG_W'(MIN_SEG - 1) + SEG_W'(lfsr[SEG_BITS-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clean_q      <= 1'b0;
            target       <= 1'b0;
            lfsr         <= LFSR_SEED;
            win_cnt      <= '0;
            seg_cnt      <= '0;
            glitch_cnt   <= '0;
            bouncy_out   <= 1'b0;
            bouncing     <= 1'b0;
            settle_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            clean_q      <= clean_in;
            target       <= target_nxt;
            lfsr         <= lfsr_nxt;
            win_cnt      <= win_nxt;
            seg_cnt      <= seg_nxt;
            glitch_cnt   <= glitch_nxt;
            bouncy_out   <= bouncy_nxt;
            bouncing     <= bouncing_nxt;
            settle_pulse <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        target_nxt   = target;
        lfsr_nxt     = lfsr;
        win_nxt      = win_cnt;
        seg_nxt      = seg_cnt;
        glitch_nxt   = glitch_cnt;
        bouncy_nxt   = bouncy_out;
        bouncing_nxt = bouncing;
        settle_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (change && !en) begin
                    bouncy_nxt = clean_in;
                end else if (change) begin
                    state_nxt    = BOUNCE;
                    target_nxt   = clean_in;
                    bouncy_nxt   = clean_in;
                    bouncing_nxt = 1'b1;
                    win_nxt      = WIN_W'(BOUNCE_CYCLES - 1);
                    glitch_nxt   = '0;
                    seg_nxt      = seg_load;
                    lfsr_nxt     = lfsr_adv;
                end
            end
            BOUNCE: begin
                if (win_cnt == '0 && !change) begin
                    // Settle to target regardless of how many toggles were issued
                    state_nxt    = IDLE;
                    bouncy_nxt   = target;
                    bouncing_nxt = 1'b0;
                    settle_nxt   = 1'b1;
                end else begin
                    if (change) begin
                        target_nxt = clean_in;
                        win_nxt    = WIN_W'(BOUNCE_CYCLES - 1);
                    end else begin
                        win_nxt = win_cnt - 1'b1;
                    end
                    if (seg_cnt == '0) begin
                        bouncy_nxt = ~bouncy_out;
                        glitch_nxt = (glitch_cnt == 16'hFFFF) ? glitch_cnt : glitch_cnt + 16'd1;
                        seg_nxt    = seg_load;
                        lfsr_nxt   = lfsr_adv;
                    end else begin
                        seg_nxt = seg_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
